// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write arbiter.
package rf_arb_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // "reg" is a keyword, so the destination field is named rd.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } md_entry_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_MD} gnt_src_t;
endpackage

// File: rtl/rf_arb_fifo.sv
// Circular holding buffer for MD results waiting on the register file port.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int MD_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  md_entry_t                     push_data,
    input  logic                          pop,
    output md_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(MD_DEPTH+1)-1:0] count
);
    localparam int PTR_W = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int CNT_W = $clog2(MD_DEPTH + 1);

    md_entry_t        mem [MD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(MD_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot for a same-cycle push even when full.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file write port between WB and the MD unit, with
// an MD pending scoreboard. Define MD_BYPASS_EN for same-cycle MD writes.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int MD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              md_valid,
    input  logic [REG_W-1:0]  md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_reg,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [REG_W-1:0]  rt_addr,
    output logic              hazard_stall,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int CNT_W = $clog2(MD_DEPTH + 1);

    md_entry_t         head;
    logic              full, empty;
    logic [CNT_W-1:0]  count;
    logic              wb_req, pop, bypass, fifo_push, stall;
    gnt_src_t          gnt;
    logic [REG_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        starve_cnt;
    logic [NUM_REGS-1:0] pending, pending_nxt;

    assign wb_req = wb_valid && (wb_reg != '0);

    always_comb begin
        gnt     = GNT_NONE;
        pop     = 1'b0;
        bypass  = 1'b0;
        stall   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (wb_req && (starve_cnt < 4'(STARVE_LIMIT))) begin
            gnt     = GNT_WB;
            wr_addr = wb_reg;
            wr_data = wb_data;
        end else if (!empty) begin
            gnt     = GNT_MD;
            pop     = 1'b1;
            stall   = wb_req;
            wr_addr = head.rd;
            wr_data = head.data;
        end
`ifdef MD_BYPASS_EN
        else if (!wb_req && md_valid && (md_reg != '0)) begin
            gnt     = GNT_MD;
            bypass  = 1'b1;
            wr_addr = md_reg;
            wr_data = md_data;
        end
`endif
    end

    // Outputs are forced quiet while reset is held.
    assign rf_we        = !reset && (gnt != GNT_NONE);
    assign rf_waddr     = rf_we ? wr_addr : '0;
    assign rf_wdata     = rf_we ? wr_data : '0;
    assign wb_stall     = !reset && stall;
    assign md_ready     = !reset && (count < CNT_W'(MD_DEPTH));
    assign hazard_stall = !reset && (pending[rs_addr] || pending[rt_addr] ||
                                     (issue_valid && pending[issue_reg]));

    // Register-0 results are accepted and dropped; bypassed results skip the FIFO.
    assign fifo_push = md_valid && !full && (md_reg != '0) && !bypass;

    rf_arb_fifo #(.MD_DEPTH(MD_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ('{rd: md_reg, data: md_data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                starve_cnt <= '0;
        else if (empty || pop)                                    starve_cnt <= '0;
        else if (gnt == GNT_WB && starve_cnt < 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end

    // Clears applied first so a same-cycle issue to that register wins.
    always_comb begin
        pending_nxt = pending;
        if (pop)    pending_nxt[head.rd] = 1'b0;
        if (bypass) pending_nxt[md_reg]  = 1'b0;
        if (issue_valid && issue_reg != '0) pending_nxt[issue_reg] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= pending_nxt;
    end
endmodule
